// File: rtl/dmem_mmio.sv
// Data-side memory for a small CPU: word RAM plus an MMIO page (LED, switches,
// cycle counter, one-shot down-counting timer). Reads are combinational.
//
// Timer states:
//   state | meaning
//   IDLE  | timer stopped, no expiry pending
//   RUN   | count decrementing toward terminal count
//   DONE  | count reached zero, irq_o held until TSTAT clear
module dmem_mmio #(
  parameter int RAM_AW = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [15:0] sw_i,
  output logic [15:0] led_o,
  output logic        irq_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } timer_state_t;

  localparam logic [7:0] OFS_LED   = 8'h00;
  localparam logic [7:0] OFS_SW    = 8'h04;
  localparam logic [7:0] OFS_CYCLE = 8'h08;
  localparam logic [7:0] OFS_TLOAD = 8'h0C;
  localparam logic [7:0] OFS_TSTAT = 8'h10;

  logic [31:0]       mem [2**RAM_AW];
  logic [15:0]       led;
  logic [31:0]       cycle;
  logic [31:0]       count;
  timer_state_t      state;

  logic              sel_ram;
  logic              sel_mmio;
  logic              wr_ok;
  logic [RAM_AW-1:0] word_idx;
  logic [7:0]        offset;
  logic              wr_led;
  logic              wr_tload;
  logic              wr_tstat;

  // Address bits above the RAM window are don't-care inside the RAM region.
  logic              unused_addr_bits;
  assign unused_addr_bits = ^addr[27:RAM_AW+2];

  assign sel_ram  = (addr[31:28] == 4'h0);
  assign sel_mmio = (addr[31:8] == 24'hFFFF00);
  assign word_idx = addr[RAM_AW+1:2];
  assign offset   = {addr[7:2], 2'b00};

  // Misaligned stores are dropped, and nothing is written while in reset.
  assign wr_ok    = memwrite && !rst && (addr[1:0] == 2'b00);
  assign wr_led   = wr_ok && sel_mmio && (offset == OFS_LED);
  assign wr_tload = wr_ok && sel_mmio && (offset == OFS_TLOAD);
  assign wr_tstat = wr_ok && sel_mmio && (offset == OFS_TSTAT);

  always_ff @(posedge clk) begin
    if (wr_ok && sel_ram) begin
      mem[word_idx] <= writedata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led   <= 16'h0000;
      cycle <= 32'h0000_0000;
    end else begin
      cycle <= cycle + 32'd1;
      if (wr_led) begin
        led <= writedata[15:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      count <= 32'h0000_0000;
    end else if (wr_tload) begin
      // A reload wins over any terminal decrement in the same cycle.
      if (writedata != 32'h0000_0000) begin
        state <= ST_RUN;
        count <= writedata;
      end else begin
        state <= ST_DONE;
        count <= 32'h0000_0000;
      end
    end else begin
      case (state)
        ST_RUN: begin
          count <= count - 32'd1;
          if (count == 32'd1) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (wr_tstat && writedata[1]) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    readdata = 32'h0000_0000;
    if (sel_ram) begin
      readdata = mem[word_idx];
    end else if (sel_mmio) begin
      case (offset)
        OFS_LED:   readdata = {16'h0000, led};
        OFS_SW:    readdata = {16'h0000, sw_i};
        OFS_CYCLE: readdata = cycle;
        OFS_TLOAD: readdata = count;
        OFS_TSTAT: readdata = {30'd0, (state == ST_DONE), (state == ST_RUN)};
        default:   readdata = 32'h0000_0000;
      endcase
    end
  end

  assign led_o = led;
  assign irq_o = (state == ST_DONE);

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed self-checking bench for dmem_mmio: RAM, MMIO registers, timer and reset.
module tb_dmem_mmio;

  logic        clk = 1'b0;
  logic        rst;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [15:0] sw_i;
  logic [15:0] led_o;
  logic        irq_o;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] A_LED   = 32'hFFFF_0000;
  localparam logic [31:0] A_SW    = 32'hFFFF_0004;
  localparam logic [31:0] A_CYCLE = 32'hFFFF_0008;
  localparam logic [31:0] A_TLOAD = 32'hFFFF_000C;
  localparam logic [31:0] A_TSTAT = 32'hFFFF_0010;

  dmem_mmio #(.RAM_AW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .memwrite  (memwrite),
    .addr      (addr),
    .writedata (writedata),
    .readdata  (readdata),
    .sw_i      (sw_i),
    .led_o     (led_o),
    .irq_o     (irq_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr      = a;
    writedata = d;
    memwrite  = 1'b1;
    step();
    memwrite  = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(tag, readdata, exp);
  endtask

  initial begin
    rst       = 1'b1;
    memwrite  = 1'b0;
    addr      = 32'h0;
    writedata = 32'h0;
    sw_i      = 16'h0000;
    step();
    step();
    rst = 1'b0;

    chk("reset_led", {16'h0, led_o}, 32'h0);
    chk("reset_irq", {31'h0, irq_o}, 32'h0);
    rd_chk("reset_tstat", A_TSTAT, 32'h0);
    rd_chk("reset_tload", A_TLOAD, 32'h0);

    // RAM: aligned write, byte-offset reads, misaligned write discarded
    wr(32'h0000_0010, 32'h1234_5678);
    rd_chk("ram_rd_10", 32'h0000_0010, 32'h1234_5678);
    rd_chk("ram_rd_13", 32'h0000_0013, 32'h1234_5678);
    wr(32'h0000_0011, 32'hFFFF_FFFF);
    rd_chk("ram_misaligned", 32'h0000_0010, 32'h1234_5678);

    // read-during-write returns the old word
    addr      = 32'h0000_0010;
    writedata = 32'hAAAA_5555;
    memwrite  = 1'b1;
    #1;
    chk("ram_rdw_old", readdata, 32'h1234_5678);
    step();
    memwrite = 1'b0;
    rd_chk("ram_rdw_new", 32'h0000_0010, 32'hAAAA_5555);

    // LED and switches
    wr(A_LED, 32'hABCD_1234);
    chk("led_o", {16'h0, led_o}, 32'h0000_1234);
    rd_chk("led_rd", A_LED, 32'h0000_1234);
    wr(32'hFFFF_0001, 32'h0000_9999);
    chk("led_misaligned", {16'h0, led_o}, 32'h0000_1234);
    sw_i = 16'h00F0;
    rd_chk("sw_rd", A_SW, 32'h0000_00F0);
    wr(A_SW, 32'h0000_FFFF);
    rd_chk("sw_wr_ignored", A_SW, 32'h0000_00F0);

    // timer: load 3, irq exactly 3 edges after load edge
    wr(A_TLOAD, 32'd3);
    chk("t3_irq_l0", {31'h0, irq_o}, 32'h0);
    rd_chk("t3_count_l0", A_TLOAD, 32'd3);
    rd_chk("t3_tstat_run", A_TSTAT, 32'h1);
    step();
    chk("t3_irq_l1", {31'h0, irq_o}, 32'h0);
    rd_chk("t3_count_l1", A_TLOAD, 32'd2);
    step();
    chk("t3_irq_l2", {31'h0, irq_o}, 32'h0);
    step();
    chk("t3_irq_l3", {31'h0, irq_o}, 32'h1);
    rd_chk("t3_tstat_done", A_TSTAT, 32'h2);
    rd_chk("t3_count_done", A_TLOAD, 32'h0);
    wr(A_TSTAT, 32'h1);
    chk("tstat_bit1_0_noop", {31'h0, irq_o}, 32'h1);
    wr(A_TSTAT, 32'h2);
    chk("tstat_clear_irq", {31'h0, irq_o}, 32'h0);
    rd_chk("tstat_clear_rd", A_TSTAT, 32'h0);

    // load of 0 expires immediately
    wr(A_TLOAD, 32'd0);
    chk("t0_irq", {31'h0, irq_o}, 32'h1);
    rd_chk("t0_tstat", A_TSTAT, 32'h2);
    wr(A_TSTAT, 32'h2);
    chk("t0_clear", {31'h0, irq_o}, 32'h0);

    // clear while running is ignored, countdown continues
    wr(A_TLOAD, 32'd4);
    wr(A_TSTAT, 32'h2);
    rd_chk("run_clear_tstat", A_TSTAT, 32'h1);
    rd_chk("run_clear_count", A_TLOAD, 32'd3);
    step();
    step();
    chk("t4_irq_e3", {31'h0, irq_o}, 32'h0);
    step();
    chk("t4_irq_e4", {31'h0, irq_o}, 32'h1);
    wr(A_TSTAT, 32'h2);

    // restart: load 5, reload 5 two cycles later, irq 5 edges after reload
    wr(A_TLOAD, 32'd5);
    step();
    wr(A_TLOAD, 32'd5);
    rd_chk("restart_count", A_TLOAD, 32'd5);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk($sformatf("restart_irq_low_%0d", i), {31'h0, irq_o}, 32'h0);
    end
    step();
    chk("restart_irq_high", {31'h0, irq_o}, 32'h1);
    wr(A_TSTAT, 32'h2);

    // reset mid-countdown; writes presented during reset are ignored
    wr(32'h0000_0040, 32'hCAFE_F00D);
    wr(A_TLOAD, 32'd10);
    step();
    step();
    rst       = 1'b1;
    memwrite  = 1'b1;
    addr      = A_LED;
    writedata = 32'h0000_5555;
    step();
    addr      = 32'h0000_0040;
    writedata = 32'h0000_0000;
    step();
    rst      = 1'b0;
    memwrite = 1'b0;
    rd_chk("rst_cycle_0", A_CYCLE, 32'h0);
    step();
    rd_chk("rst_cycle_1", A_CYCLE, 32'h1);
    rd_chk("rst_tstat", A_TSTAT, 32'h0);
    chk("rst_irq", {31'h0, irq_o}, 32'h0);
    chk("rst_led", {16'h0, led_o}, 32'h0);
    rd_chk("rst_ram_kept", 32'h0000_0040, 32'hCAFE_F00D);
    for (int i = 0; i < 12; i++) step();
    chk("rst_no_late_irq", {31'h0, irq_o}, 32'h0);

    // unmapped addresses
    wr(32'h0000_0000, 32'h1111_1111);
    wr(A_LED, 32'h0000_00A5);
    rd_chk("unmapped_rd_2000", 32'h2000_0000, 32'h0);
    rd_chk("unmapped_rd_ff20", 32'hFFFF_0020, 32'h0);
    wr(32'h2000_0000, 32'hDEAD_BEEF);
    wr(32'hFFFF_0020, 32'hDEAD_BEEF);
    rd_chk("unmapped_ram0", 32'h0000_0000, 32'h1111_1111);
    rd_chk("unmapped_ram40", 32'h0000_0040, 32'hCAFE_F00D);
    chk("unmapped_led", {16'h0, led_o}, 32'h0000_00A5);
    rd_chk("unmapped_tstat", A_TSTAT, 32'h0);
    rd_chk("unmapped_rd_after", 32'hFFFF_0020, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
